// File: rtl/snn_ecg_pkg.sv
// rtl/snn_ecg_pkg.sv - shared widths, FSM states and saturating increment for the ECG frame driver
package snn_ecg_pkg;

    localparam int N_IN  = 30;
    localparam int N_OUT = 5;
    localparam int CLS_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ENC    = 3'd1,
        ST_KICK   = 3'd2,
        ST_WAIT   = 3'd3,
        ST_ARGMAX = 3'd4,
        ST_RESULT = 3'd5
    } state_e;

    // Counters up to 16 bits wide; callers zero-extend and pass their own ceiling.
    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic [15:0] max_v);
        return (v >= max_v) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/snn_rate_encoder.sv
// rtl/snn_rate_encoder.sv - per-channel 8b accumulate-and-fire rate encoder
module snn_rate_encoder
    import snn_ecg_pkg::*;
#(
    parameter int N_CH = N_IN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              step_en_i,
    input  logic [N_CH*8-1:0] frame_data_i,
    output logic [N_CH-1:0]   spikes_o
);

    logic [N_CH-1:0][7:0] acc_q;
    logic [N_CH-1:0][8:0] sum_d;
    logic [N_CH-1:0]      spikes_q;

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            sum_d[i] = {1'b0, acc_q[i]} + {1'b0, frame_data_i[8*i +: 8]};
        end
    end

    // The carry out of each 8b accumulator is the spike; the residue carries over.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            spikes_q <= '0;
        end else if (clr_i) begin
            acc_q    <= '0;
            spikes_q <= '0;
        end else if (step_en_i) begin
            for (int i = 0; i < N_CH; i++) begin
                acc_q[i]    <= sum_d[i][7:0];
                spikes_q[i] <= sum_d[i][8];
            end
        end
    end

    assign spikes_o = spikes_q;

endmodule

// File: rtl/snn_ecg_frame_driver.sv
// rtl/snn_ecg_frame_driver.sv - frame-level start/done initiator, spike counting and argmax for the ECG SNN
module snn_ecg_frame_driver
    import snn_ecg_pkg::*;
#(
    parameter int T_STEPS = 32,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   frame_valid,
    output logic                   frame_ready,
    input  logic [N_IN*8-1:0]      frame_data,
    output logic                   net_start,
    output logic [N_IN-1:0]        net_spikes_in,
    input  logic                   net_done,
    input  logic [N_OUT-1:0]       net_spikes_out,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic [CLS_W-1:0]       result_class,
    output logic [N_OUT*CNT_W-1:0] result_counts,
    output logic                   result_err,
    output logic                   busy
);

    localparam int          WC_W    = $clog2(TIMEOUT + 1);
    localparam logic [15:0] CNT_MAX = 16'((1 << CNT_W) - 1);

    state_e                      state_q;
    logic [N_IN*8-1:0]           frame_q;
    logic [7:0]                  step_q;
    logic [WC_W-1:0]             wcnt_q;
    logic [N_OUT-1:0][CNT_W-1:0] cnt_q;
    logic                        err_q;
    logic [CLS_W-1:0]            idx_q;
    logic [CLS_W-1:0]            best_idx_q;
    logic [CNT_W-1:0]            best_cnt_q;
    logic                        net_start_q;
    logic                        frame_ready_q;
    logic                        busy_q;
    logic                        result_valid_q;
    logic                        result_err_q;
    logic [CLS_W-1:0]            result_class_q;
    logic [N_OUT*CNT_W-1:0]      result_counts_q;

    logic                        accept;
    logic                        enc_step;
    logic [CNT_W-1:0]            cur_cnt;
    logic                        cur_better;
    logic [CLS_W-1:0]            best_idx_d;

    assign accept   = frame_valid && frame_ready_q;
    assign enc_step = (state_q == ST_ENC);

    snn_rate_encoder #(.N_CH(N_IN)) u_enc (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr_i        (accept),
        .step_en_i    (enc_step),
        .frame_data_i (frame_q),
        .spikes_o     (net_spikes_in)
    );

    // Strict '>' keeps the lowest index on ties and on an all-zero frame.
    always_comb begin
        cur_cnt    = (idx_q < CLS_W'(N_OUT)) ? cnt_q[idx_q] : '0;
        cur_better = (cur_cnt > best_cnt_q);
        best_idx_d = cur_better ? idx_q : best_idx_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            frame_q         <= '0;
            step_q          <= '0;
            wcnt_q          <= '0;
            cnt_q           <= '0;
            err_q           <= 1'b0;
            idx_q           <= '0;
            best_idx_q      <= '0;
            best_cnt_q      <= '0;
            net_start_q     <= 1'b0;
            frame_ready_q   <= 1'b1;
            busy_q          <= 1'b0;
            result_valid_q  <= 1'b0;
            result_err_q    <= 1'b0;
            result_class_q  <= '0;
            result_counts_q <= '0;
        end else begin
            net_start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        frame_q       <= frame_data;
                        cnt_q         <= '0;
                        step_q        <= '0;
                        err_q         <= 1'b0;
                        idx_q         <= '0;
                        best_idx_q    <= '0;
                        best_cnt_q    <= '0;
                        frame_ready_q <= 1'b0;
                        busy_q        <= 1'b1;
                        state_q       <= ST_ENC;
                    end
                end
                ST_ENC: begin
                    net_start_q <= 1'b1;
                    state_q     <= ST_KICK;
                end
                ST_KICK: begin
                    wcnt_q  <= '0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (net_done) begin
                        for (int k = 0; k < N_OUT; k++) begin
                            if (net_spikes_out[k]) begin
                                cnt_q[k] <= CNT_W'(sat_inc(16'(cnt_q[k]), CNT_MAX));
                            end
                        end
                        step_q  <= step_q + 8'd1;
                        state_q <= (step_q == 8'(T_STEPS - 1)) ? ST_ARGMAX : ST_ENC;
                    end else if (wcnt_q == WC_W'(TIMEOUT - 1)) begin
                        err_q   <= 1'b1;
                        state_q <= ST_ARGMAX;
                    end else begin
                        wcnt_q <= wcnt_q + 1'b1;
                    end
                end
                ST_ARGMAX: begin
                    best_idx_q <= best_idx_d;
                    best_cnt_q <= cur_better ? cur_cnt : best_cnt_q;
                    idx_q      <= idx_q + 1'b1;
                    if (idx_q == CLS_W'(N_OUT - 1)) begin
                        result_class_q  <= best_idx_d;
                        result_counts_q <= cnt_q;
                        result_err_q    <= err_q;
                        result_valid_q  <= 1'b1;
                        state_q         <= ST_RESULT;
                    end
                end
                ST_RESULT: begin
                    if (result_ready) begin
                        result_valid_q <= 1'b0;
                        frame_ready_q  <= 1'b1;
                        busy_q         <= 1'b0;
                        state_q        <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign frame_ready   = frame_ready_q;
    assign net_start     = net_start_q;
    assign result_valid  = result_valid_q;
    assign result_class  = result_class_q;
    assign result_counts = result_counts_q;
    assign result_err    = result_err_q;
    assign busy          = busy_q;

endmodule
